mem_access_unit: RTL

Memory-stage data-memory controller for the LC-3b pipeline. Takes one load/store request from the EX/MEM pipeline register, drives the data-memory port (including the two-access indirect forms LDI/STI), and stalls the pipeline until the access completes. It produces the load word and byte select that the writeback stage consumes (`mem_wdata`, `byte_sel`), and it is the write-side counterpart of the writeback load path.

---
 rtl/mem_access_unit.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// LC-3b memory-stage controller: drives the data-memory port for LDW/LDB/STW/STB/LDI/STI,
// stalls the pipeline while an access is outstanding and registers the load word for writeback.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_address,
  input  logic [15:0] req_data,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic [15:0] mem_wdata,
  output logic        byte_sel,
  output logic        stall,
  output logic        done
);

  localparam logic [2:0] OP_LDW = 3'b000;
  localparam logic [2:0] OP_LDB = 3'b001;
  localparam logic [2:0] OP_STW = 3'b010;
  localparam logic [2:0] OP_STB = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;
  localparam logic [2:0] OP_STI = 3'b101;

  typedef enum logic [1:0] {IDLE, IND, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  op_p1;
  logic [15:0] addr_p1;
  logic [15:0] data_p1;
  logic [15:0] word_addr;
  logic        req_ok;
  logic        is_load;

  function automatic logic [1:0] stb_enable(input logic lsb);
    return lsb ? 2'b10 : 2'b01;
  endfunction

  assign req_ok    = req_valid && (req_op <= OP_STI);
  assign is_load   = (op_p1 == OP_LDW) || (op_p1 == OP_LDB) || (op_p1 == OP_LDI);
  assign word_addr = {addr_p1[15:1], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request latch; in IND the address register is overwritten with the fetched pointer
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (req_ok) begin
          op_p1   <= req_op;
          addr_p1 <= req_address;
          data_p1 <= req_data;
        end
      end
      IND: begin
        if (dmem_resp) addr_p1 <= dmem_rdata;
      end
      default: ;
    endcase
  end

  // Load result register; stores leave it untouched
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_wdata <= 16'h0000;
      byte_sel  <= 1'b0;
    end else if (state == ACCESS && dmem_resp && is_load) begin
      mem_wdata <= dmem_rdata;
      byte_sel  <= (op_p1 == OP_LDB) && addr_p1[0];
    end
  end

  always_comb begin
    state_next       = state;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;
    stall            = 1'b0;
    done             = 1'b0;
    case (state)
      IDLE: begin
        if (req_ok) begin
          stall      = 1'b1;
          state_next = (req_op == OP_LDI || req_op == OP_STI) ? IND : ACCESS;
        end
      end
      IND: begin
        stall            = 1'b1;
        dmem_read        = 1'b1;
        dmem_address     = word_addr;
        dmem_byte_enable = 2'b11;
        if (dmem_resp) state_next = ACCESS;
      end
      ACCESS: begin
        stall        = 1'b1;
        dmem_address = word_addr;
        case (op_p1)
          OP_STW, OP_STI: begin
            dmem_write       = 1'b1;
            dmem_byte_enable = 2'b11;
            dmem_wdata       = data_p1;
          end
          OP_STB: begin
            dmem_write       = 1'b1;
            dmem_byte_enable = stb_enable(addr_p1[0]);
            dmem_wdata       = {data_p1[7:0], data_p1[7:0]};
          end
          default: begin
            dmem_read        = 1'b1;
            dmem_byte_enable = 2'b11;
          end
        endcase
        if (dmem_resp) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
